// File: rtl/rdi_tx_arbiter_if.sv
// Bundles the three requester handshakes, the RDI transmit side and the credit/status signals.
// Carries no state, so it adds no latency.
// Backpressure is ready/valid per requester, and pl_trdy on the RDI side.
interface rdi_tx_arbiter_if #(
  parameter int NBYTES = 64,
  parameter int CRD_W  = 4
);
  logic                  enable;
  logic                  tx_valid;
  logic [NBYTES*8-1:0]   tx_data;
  logic                  tx_ready;
  logic                  crd_valid;
  logic [NBYTES*8-1:0]   crd_data;
  logic                  crd_ready;
  logic                  rsp_valid;
  logic [NBYTES*8-1:0]   rsp_data;
  logic                  rsp_ready;
  logic                  crd_rcv_i;
  logic                  pl_trdy;
  logic [NBYTES*8-1:0]   lp_data;
  logic                  lp_valid;
  logic                  lp_irdy;
  logic [CRD_W-1:0]      tx_crd_cnt;
  logic                  err_crd_ovf;

  // Environment side: the flit formatters plus the physical layer.
  modport master (
    output enable, tx_valid, tx_data, crd_valid, crd_data, rsp_valid, rsp_data,
           crd_rcv_i, pl_trdy,
    input  tx_ready, crd_ready, rsp_ready, lp_data, lp_valid, lp_irdy,
           tx_crd_cnt, err_crd_ovf
  );

  // Arbiter side.
  modport slave (
    input  enable, tx_valid, tx_data, crd_valid, crd_data, rsp_valid, rsp_data,
           crd_rcv_i, pl_trdy,
    output tx_ready, crd_ready, rsp_ready, lp_data, lp_valid, lp_irdy,
           tx_crd_cnt, err_crd_ovf
  );
endinterface

// File: rtl/rdi_tx_arbiter.sv
// Shares the RDI transmit flit slot between crd, rsp and credit-gated tx, with fixed priority and a tx starvation override.
// A granted flit appears on lp_data/lp_valid one cycle after its *_ready.
// The output register holds until pl_trdy, and the readies stay low while it is full and not draining.
module rdi_tx_arbiter #(
  parameter int NBYTES     = 64,
  parameter int CRD_W      = 4,
  parameter int CRD_INIT   = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  rdi_tx_arbiter_if.slave bus
);
  localparam int DW = NBYTES * 8;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = '1;

  logic [CRD_W-1:0] crd_cnt;
  logic [SW-1:0]    starve_cnt;
  logic             lp_valid_q;
  logic [DW-1:0]    lp_data_q;
  logic             ovf_q;

  logic             load;
  logic             tx_e;
  logic             starved;
  logic             gnt_crd;
  logic             gnt_rsp;
  logic             gnt_tx;
  logic [DW-1:0]    gnt_data;

  // The slot can take a new flit when it is empty or its current flit is leaving this cycle.
  assign load    = bus.enable & (~lp_valid_q | bus.pl_trdy);
  assign tx_e    = bus.tx_valid & (crd_cnt != '0);
  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // One-hot grant: a starved tx wins outright, otherwise crd > rsp > tx.
  always_comb begin
    gnt_crd = 1'b0;
    gnt_rsp = 1'b0;
    gnt_tx  = 1'b0;
    if (load) begin
      if (tx_e && starved)    gnt_tx  = 1'b1;
      else if (bus.crd_valid) gnt_crd = 1'b1;
      else if (bus.rsp_valid) gnt_rsp = 1'b1;
      else if (tx_e)          gnt_tx  = 1'b1;
    end
  end

  // Payload of the winning source; zero when nothing is granted so idle data reads as zeros.
  always_comb begin
    gnt_data = '0;
    if (gnt_crd)     gnt_data = bus.crd_data;
    else if (gnt_rsp) gnt_data = bus.rsp_data;
    else if (gnt_tx)  gnt_data = bus.tx_data;
  end

  assign bus.crd_ready   = gnt_crd;
  assign bus.rsp_ready   = gnt_rsp;
  assign bus.tx_ready    = gnt_tx;
  assign bus.lp_data     = lp_data_q;
  assign bus.lp_valid    = lp_valid_q;
  assign bus.lp_irdy     = lp_valid_q;
  assign bus.tx_crd_cnt  = crd_cnt;
  assign bus.err_crd_ovf = ovf_q;

  // Output register: refill on load, and drain to idle when disabled and the held flit is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_valid_q <= 1'b0;
      lp_data_q  <= '0;
    end else if (load) begin
      lp_valid_q <= gnt_crd | gnt_rsp | gnt_tx;
      lp_data_q  <= gnt_data;
    end else if (bus.pl_trdy) begin
      lp_valid_q <= 1'b0;
      lp_data_q  <= '0;
    end
  end

  // Remote tx credits: a return and a tx grant in the same cycle cancel; overflow saturates and latches an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crd_cnt <= CRD_W'(CRD_INIT);
      ovf_q   <= 1'b0;
    end else if (bus.crd_rcv_i && !gnt_tx) begin
      if (crd_cnt == CRD_MAX) ovf_q   <= 1'b1;
      else                    crd_cnt <= crd_cnt + CRD_W'(1);
    end else if (!bus.crd_rcv_i && gnt_tx) begin
      crd_cnt <= crd_cnt - CRD_W'(1);
    end
  end

  // Starvation count: arbitrations an eligible tx lost to crd/rsp since its last grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt_tx) begin
      starve_cnt <= '0;
    end else if ((gnt_crd || gnt_rsp) && tx_e && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_rdi_tx_arbiter.sv
// Directed and random checks of rdi_tx_arbiter against a cycle-level reference model.
// Checks the readies before each edge and the registered RDI/credit outputs after it.
// Random traffic keeps each request's valid and data stable until it is granted.
module tb_rdi_tx_arbiter;
  localparam int NB = 64;
  localparam int DW = NB * 8;
  localparam int CW = 4;
  localparam int CI = 8;
  localparam int SM = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;

  rdi_tx_arbiter_if #(.NBYTES(NB), .CRD_W(CW)) bus ();

  rdi_tx_arbiter #(.NBYTES(NB), .CRD_W(CW), .CRD_INIT(CI), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state. Grants are coded 0 none, 1 crd, 2 rsp, 3 tx.
  int            m_crd;
  int            m_starve;
  bit            m_ovf;
  bit            m_vld;
  logic [DW-1:0] m_dat;
  int            last_g;

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_crd    = CI;
    m_starve = 0;
    m_ovf    = 0;
    m_vld    = 0;
    m_dat    = '0;
    last_g   = 0;
  endtask

  // One clock: called just after a negedge with inputs already driven, returns at the next negedge.
  task automatic cycle();
    int g;
    bit ld;
    bit txe;
    #1;
    ld  = bus.enable && (!m_vld || bus.pl_trdy);
    txe = bus.tx_valid && (m_crd > 0);
    g   = 0;
    if (ld) begin
      if (txe && m_starve >= SM) g = 3;
      else if (bus.crd_valid)    g = 1;
      else if (bus.rsp_valid)    g = 2;
      else if (txe)              g = 3;
    end
    chk_b("crd_ready", bus.crd_ready, g == 1);
    chk_b("rsp_ready", bus.rsp_ready, g == 2);
    chk_b("tx_ready",  bus.tx_ready,  g == 3);

    if (ld) begin
      m_vld = (g != 0);
      m_dat = (g == 1) ? bus.crd_data : (g == 2) ? bus.rsp_data : (g == 3) ? bus.tx_data : '0;
    end else if (bus.pl_trdy) begin
      m_vld = 0;
      m_dat = '0;
    end
    m_crd = m_crd + int'(bus.crd_rcv_i) - ((g == 3) ? 1 : 0);
    if (m_crd > CMAX) begin
      m_crd = CMAX;
      m_ovf = 1;
    end
    if (g == 3) m_starve = 0;
    else if (g != 0 && txe) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
    last_g = g;

    @(posedge clk);
    #1;
    chk_b("lp_valid",    bus.lp_valid,    m_vld);
    chk_b("lp_irdy",     bus.lp_irdy,     m_vld);
    chk_w("lp_data",     bus.lp_data,     m_dat);
    chk_i("tx_crd_cnt",  32'(bus.tx_crd_cnt), m_crd);
    chk_b("err_crd_ovf", bus.err_crd_ovf, m_ovf);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.tx_valid  = 1'b0;
    bus.crd_valid = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.crd_rcv_i = 1'b0;
  endtask

  int            ntx;
  int            ngnt;
  logic [DW-1:0] held;
  logic [DW-1:0] dc, dr, dt;

  initial begin
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.pl_trdy   = 1'b0;
    bus.tx_data   = '0;
    bus.crd_data  = '0;
    bus.rsp_data  = '0;
    idle_inputs();
    model_reset();
    #3;
    chk_b("rst_lp_valid", bus.lp_valid, 1'b0);
    chk_b("rst_lp_irdy",  bus.lp_irdy,  1'b0);
    chk_w("rst_lp_data",  bus.lp_data,  '0);
    chk_i("rst_crd_cnt",  32'(bus.tx_crd_cnt), CI);
    chk_b("rst_ovf",      bus.err_crd_ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Credit-limited tx burst, then three returned credits.
    bus.enable   = 1'b1;
    bus.pl_trdy  = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = rnd();
    ntx = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_g == 3) begin ntx++; bus.tx_data = rnd(); end
    end
    chk_i("burst_tx_count", ntx, CI);
    chk_i("burst_crd_empty", 32'(bus.tx_crd_cnt), 0);
    chk_b("burst_tx_ready_low", bus.tx_ready, 1'b0);
    ntx = 0;
    for (int i = 0; i < 8; i++) begin
      bus.crd_rcv_i = (i < 3);
      cycle();
      if (last_g == 3) begin ntx++; bus.tx_data = rnd(); end
    end
    bus.crd_rcv_i = 1'b0;
    chk_i("returned_tx_count", ntx, 3);

    // Fixed priority with all three requesting together.
    bus.tx_valid  = 1'b0;
    bus.crd_rcv_i = 1'b1;
    repeat (4) cycle();
    bus.crd_rcv_i = 1'b0;
    dc = rnd(); dr = rnd(); dt = rnd();
    bus.crd_data = dc; bus.rsp_data = dr; bus.tx_data = dt;
    bus.crd_valid = 1'b1; bus.rsp_valid = 1'b1; bus.tx_valid = 1'b1;
    cycle();
    chk_i("prio_first", last_g, 1);
    chk_w("prio_first_data", bus.lp_data, dc);
    bus.crd_valid = 1'b0;
    cycle();
    chk_i("prio_second", last_g, 2);
    chk_w("prio_second_data", bus.lp_data, dr);
    bus.rsp_valid = 1'b0;
    cycle();
    chk_i("prio_third", last_g, 3);
    chk_w("prio_third_data", bus.lp_data, dt);
    bus.tx_valid = 1'b0;

    // Fill credits, then crd and tx both held: tx wins every fifth slot.
    bus.crd_rcv_i = 1'b1;
    repeat (12) cycle();
    bus.crd_rcv_i = 1'b0;
    chk_i("fill_crd_cnt", 32'(bus.tx_crd_cnt), CMAX);
    bus.crd_valid = 1'b1; bus.crd_data = rnd();
    bus.tx_valid  = 1'b1; bus.tx_data  = rnd();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk_i("starve_pattern", last_g, (i % 5 == 4) ? 3 : 1);
      if (last_g == 1) bus.crd_data = rnd();
      if (last_g == 3) bus.tx_data  = rnd();
    end
    idle_inputs();

    // Backpressure: held flit stays put, then the next one follows with no bubble.
    bus.rsp_valid = 1'b1; bus.rsp_data = rnd();
    bus.tx_valid  = 1'b1;
    cycle();
    held = bus.rsp_data;
    bus.rsp_data = rnd();
    bus.pl_trdy  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk_w("hold_data", bus.lp_data, held);
      chk_b("hold_no_ready", bus.crd_ready | bus.rsp_ready | bus.tx_ready, 1'b0);
    end
    bus.pl_trdy = 1'b1;
    held = bus.rsp_data;
    cycle();
    chk_b("no_bubble_valid", bus.lp_valid, 1'b1);
    chk_w("no_bubble_data", bus.lp_data, held);
    idle_inputs();
    cycle();

    // Credit overflow saturates and latches; return coincident with a tx grant is neutral.
    bus.crd_rcv_i = 1'b1;
    repeat (3) cycle();
    chk_i("ovf_cnt_sat", 32'(bus.tx_crd_cnt), CMAX);
    chk_b("ovf_set", bus.err_crd_ovf, 1'b1);
    bus.tx_valid = 1'b1; bus.tx_data = rnd();
    cycle();
    chk_i("coincident_grant", last_g, 3);
    chk_i("coincident_cnt", 32'(bus.tx_crd_cnt), CMAX);
    idle_inputs();
    cycle();
    chk_b("ovf_sticky", bus.err_crd_ovf, 1'b1);

    // Asynchronous reset while a flit is held.
    bus.tx_valid = 1'b1; bus.tx_data = rnd();
    cycle();
    bus.tx_valid = 1'b0;
    bus.pl_trdy  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_b("arst_lp_valid", bus.lp_valid, 1'b0);
    chk_w("arst_lp_data",  bus.lp_data,  '0);
    chk_i("arst_crd_cnt",  32'(bus.tx_crd_cnt), CI);
    chk_b("arst_ovf",      bus.err_crd_ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // enable low: no grants, held flit still drains, credits still count.
    bus.tx_valid = 1'b1; bus.tx_data = rnd();
    cycle();
    bus.tx_data   = rnd();
    bus.enable    = 1'b0;
    bus.crd_valid = 1'b1; bus.crd_data = rnd();
    bus.rsp_valid = 1'b1; bus.rsp_data = rnd();
    bus.crd_rcv_i = 1'b1;
    cycle();
    bus.crd_rcv_i = 1'b0;
    chk_i("dis_crd_count", 32'(bus.tx_crd_cnt), CI);
    ngnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.pl_trdy = (i >= 2);
      cycle();
      if (last_g != 0) ngnt++;
    end
    chk_i("dis_no_grants", ngnt, 0);
    chk_b("dis_drained", bus.lp_valid, 1'b0);
    bus.enable = 1'b1;
    cycle();
    chk_i("reenable_grant", last_g, 1);
    idle_inputs();
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.pl_trdy   = ($urandom_range(0, 3) != 0);
      bus.crd_rcv_i = ($urandom_range(0, 4) == 0);
      if (!bus.crd_valid || last_g == 1) begin
        bus.crd_valid = ($urandom_range(0, 2) == 0); bus.crd_data = rnd();
      end
      if (!bus.rsp_valid || last_g == 2) begin
        bus.rsp_valid = ($urandom_range(0, 2) == 0); bus.rsp_data = rnd();
      end
      if (!bus.tx_valid || last_g == 3) begin
        bus.tx_valid = ($urandom_range(0, 1) == 0); bus.tx_data = rnd();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
